uart_image_loader: RTL
======================

// Module: uart_image_loader
// PURPOSE
//   Receive side of the host-to-SNN image download. Consumes bytes from the
//   uart_rx block and unpacks each into 8 one-bit pixel writes to the 1-bit-wide
//   input-image RAM. Writes one byte per 8 clocks, on consecutive addresses from 0.
//   Flags done after NUM_PIXELS pixels (98 bytes for 784), then holds until the
//   SNN core acknowledges.
// PARAMETERS
//   NUM_PIXELS  784  pixels per image; must be a multiple of 8
//   ADDR_WIDTH  10   width of the image RAM address; 2**ADDR_WIDTH >= NUM_PIXELS
// PORTS
//   clk        in   1           system clock
//   rst        in   1           asynchronous reset, active high
//   rx_rdy     in   1           one-cycle strobe from uart_rx: rx_data valid
//   rx_data    in   8           received byte; bit0 = lowest-numbered pixel
//   load_ack   in   1           core done with image; re-arm loader (level, sampled)
//   ram_we     out  1           image RAM write enable
//   ram_addr   out  ADDR_WIDTH  image RAM write address
//   ram_data   out  1           pixel bit being written
//   busy       out  1           high in SHIFT state
//   done       out  1           full image written; held until load_ack
//   overrun    out  1           sticky: byte lost (hold reg full); cleared by load_ack/rst
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, pixel counter=0, hold reg empty.
//     All outputs are 0: ram_we, ram_addr, ram_data, busy, done, overrun.
//     Reset mid-image abandons the image; the next image restarts at addr 0.
//   Datapath:
//     shift reg sh[7:0], bit index b[2:0], pixel counter p[ADDR_WIDTH-1:0].
//     1-byte hold reg hbuf with valid bit hv.
//   IDLE:
//     rx_rdy=1 -> sh<=rx_data, b<=0, go SHIFT.
//   SHIFT, each cycle (registered outputs):
//     ram_we=1, ram_addr=p, ram_data=sh[b]; p<=p+1, b<=b+1.
//     Latency: byte strobed at edge N is written at edges N+1..N+8, addr base..base+7.
//   SHIFT, after the b=7 cycle:
//     if p+1==NUM_PIXELS -> DONE;
//     else if hv=1 -> sh<=hbuf, hv<=0, b<=0, stay SHIFT (no bubble);
//     else -> IDLE.
//   rx_rdy during SHIFT:
//     hv=0 -> hbuf<=rx_data, hv<=1;
//     hv=1 -> byte dropped, overrun<=1.
//     Same-cycle pop and push: the pop (hbuf->sh) and the load of the new byte
//     both happen, and hv stays 1. No loss.
//   DONE:
//     done=1, ram_we=0; rx_rdy ignored (dropped, no overrun).
//     hv is cleared when entering DONE.
//   load_ack=1 (any state):
//     p<=0, hv<=0, done<=0, overrun<=0, state<=IDLE.
//     A simultaneous rx_rdy is dropped.
//   ram_we=0 in every state except SHIFT.
//   ram_addr holds its last value when ram_we=0.
//   Counter arithmetic: p compares against NUM_PIXELS-1 and never wraps past it.
//   rx_data bit k maps to pixel 8*byte_index+k (LSB first).
// TESTING
//   1. rst pulse mid-run -> all outputs 0 immediately (async); the next byte
//      writes from addr 0.
//   2. Single byte 8'hA5 from IDLE -> 8 writes, addr 0..7, data 1,0,1,0,0,1,0,1;
//      busy for 8 cycles, then IDLE.
//   3. 98 bytes at UART rate (2604 clk/bit) from an image file -> RAM matches
//      784 bits; done rises one cycle after the addr-783 write; overrun=0.
//   4. Back-to-back strobes 3 cycles apart (8'hFF, 8'h00) -> 16 contiguous
//      writes, no bubble; a third strobe during the first byte sets overrun=1.
//   5. In DONE, strobe 8'h11 -> no write, done stays 1; load_ack -> done=0,
//      overrun=0; next byte writes addr 0.
//   6. rx_rdy on the same cycle SHIFT pops hbuf -> both bytes written in order;
//      overrun=0.

Source files
------------

// File: rtl/uart_image_loader.sv
// Unpacks received UART bytes into one-bit pixel writes for the SNN input-image RAM.
// One byte becomes eight consecutive writes, LSB first, starting at address 0.
module uart_image_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_rdy,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_load_ack,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastPix = ADDR_WIDTH'(NUM_PIXELS - 1);

    state_e                r_state, w_next_state;
    logic [7:0]            r_sh, w_sh_d;
    logic [2:0]            r_b, w_b_d;
    logic [ADDR_WIDTH-1:0] r_p, w_p_d;
    logic [7:0]            r_hbuf, w_hbuf_d;
    logic                  r_hv, w_hv_d;
    logic                  r_we, w_we_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic                  r_data, w_data_d;
    logic                  r_done, w_done_d;
    logic                  r_ovr, w_ovr_d;

    logic w_last_bit, w_last_pix;
    assign w_last_bit = (r_b == 3'd7);
    assign w_last_pix = (r_p == LastPix);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_load_ack) begin
            w_next_state = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (i_rx_rdy) w_next_state = StShift;
                StShift: begin
                    if (w_last_bit) begin
                        if (w_last_pix)              w_next_state = StDone;
                        else if (r_hv || i_rx_rdy)   w_next_state = StShift;
                        else                         w_next_state = StIdle;
                    end
                end
                StDone:  w_next_state = StDone;
                default: w_next_state = StIdle;
            endcase
        end
    end

    always_comb begin
        w_sh_d   = r_sh;
        w_b_d    = r_b;
        w_p_d    = r_p;
        w_hbuf_d = r_hbuf;
        w_hv_d   = r_hv;
        w_we_d   = 1'b0;
        w_addr_d = r_addr;
        w_data_d = r_data;
        w_done_d = r_done;
        w_ovr_d  = r_ovr;
        if (i_load_ack) begin
            w_p_d    = '0;
            w_hv_d   = 1'b0;
            w_done_d = 1'b0;
            w_ovr_d  = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_rx_rdy) begin
                        w_sh_d = i_rx_data;
                        w_b_d  = 3'd0;
                    end
                end
                StShift: begin
                    w_we_d   = 1'b1;
                    w_addr_d = r_p;
                    w_data_d = r_sh[r_b];
                    w_b_d    = r_b + 3'd1;
                    if (!w_last_pix) w_p_d = r_p + ADDR_WIDTH'(1);
                    if (w_last_bit && !w_last_pix && r_hv) begin
                        // Pop the hold reg; a byte arriving now refills it.
                        w_sh_d = r_hbuf;
                        w_hv_d = i_rx_rdy;
                        if (i_rx_rdy) w_hbuf_d = i_rx_data;
                    end else if (w_last_bit && !w_last_pix && i_rx_rdy) begin
                        w_sh_d = i_rx_data;
                    end else if (i_rx_rdy) begin
                        if (r_hv) begin
                            w_ovr_d = 1'b1;
                        end else begin
                            w_hbuf_d = i_rx_data;
                            w_hv_d   = 1'b1;
                        end
                    end
                    if (w_last_bit && w_last_pix) w_hv_d = 1'b0;
                end
                StDone:  w_done_d = 1'b1;
                default: w_done_d = r_done;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh   <= '0;
            r_b    <= '0;
            r_p    <= '0;
            r_hbuf <= '0;
            r_hv   <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= 1'b0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_sh   <= w_sh_d;
            r_b    <= w_b_d;
            r_p    <= w_p_d;
            r_hbuf <= w_hbuf_d;
            r_hv   <= w_hv_d;
            r_we   <= w_we_d;
            r_addr <= w_addr_d;
            r_data <= w_data_d;
            r_done <= w_done_d;
            r_ovr  <= w_ovr_d;
        end
    end

    assign o_ram_we   = r_we;
    assign o_ram_addr = r_addr;
    assign o_ram_data = r_data;
    assign o_busy     = (r_state == StShift);
    assign o_done     = r_done;
    assign o_overrun  = r_ovr;

endmodule
